lvds_rx_deser_align: RTL

LVDS_RX_DESER_ALIGN -- requirements
Module: lvds_rx_deser_align

---
 rtl/lvds_pkg.sv | 13 +
 rtl/lvds_shift_deser.sv | 48 ++++
 rtl/lvds_rx_deser_align.sv | 112 +++++++++++
 3 files changed

// File: rtl/lvds_pkg.sv
// Shared types and constants for the LVDS receive deserializer and word aligner.
package lvds_pkg;

  localparam int WORD_W = 8;
  localparam logic [WORD_W-1:0] TRAIN_WORD_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

endpackage

// File: rtl/lvds_shift_deser.sv
// Serial-to-parallel front end: shift register, word bit counter and bitslip.
// A slip stretches the following word period to WORD_W+1 cycles.
module lvds_shift_deser
  import lvds_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  input  logic              clear,
  input  logic              slip,
  output logic [WORD_W-1:0] candidate,
  output logic              boundary
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  logic [WORD_W-2:0] sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic              hold;

  // The newest bit is used combinationally so a word is complete on its 8th edge.
  assign candidate = {sr, serial_in};
  assign boundary  = (bit_cnt == LAST_BIT);

  // NOTE: reset is synchronous, so it sits inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
      hold    <= 1'b0;
    end else begin
      sr <= candidate[WORD_W-2:0];
      if (clear) begin
        bit_cnt <= '0;
        hold    <= 1'b0;
      end else if (boundary) begin
        bit_cnt <= '0;
        hold    <= slip;
      end else if (hold) begin
        hold <= 1'b0;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/lvds_rx_deser_align.sv
// LVDS receive deserializer with training-word alignment (SEARCH/VERIFY/LOCKED)
// and registered word output once locked.
module lvds_rx_deser_align
  import lvds_pkg::*;
#(
  parameter logic [WORD_W-1:0] TRAIN_WORD   = TRAIN_WORD_DEFAULT,
  parameter int                LOCK_COUNT   = 4,
  parameter int                SEARCH_LIMIT = 32
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              serial_in,
  input  logic              resync,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              locked,
  output logic [2:0]        slip_cnt,
  output logic              align_err
);

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);
  localparam logic [7:0] MISS_LAST = 8'(SEARCH_LIMIT - 1);
  localparam logic [7:0] MISS_MAX  = 8'(SEARCH_LIMIT);

  state_t            state, next_state;
  logic [3:0]        match_cnt;
  logic [7:0]        miss_cnt;
  logic [WORD_W-1:0] candidate;
  logic              boundary, is_match;
  logic              slip, miss_inc, match_first, match_inc, match_clr, load_data;

  lvds_shift_deser u_deser (
    .clk       (refclk),
    .rst_n     (rst_n),
    .serial_in (serial_in),
    .clear     (resync),
    .slip      (slip),
    .candidate (candidate),
    .boundary  (boundary)
  );

  assign is_match = (candidate == TRAIN_WORD);
  assign locked   = (state == LOCKED);

  always_ff @(posedge refclk) begin
    if (!rst_n) state <= SEARCH;
    else        state <= next_state;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    if (resync) begin
      next_state = SEARCH;
    end else if (boundary) begin
      case (state)
        SEARCH:  if (is_match) next_state = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
        VERIFY:  if (!is_match) next_state = SEARCH;
                 else if (match_cnt == LOCK_LAST) next_state = LOCKED;
        LOCKED:  next_state = LOCKED;
        default: next_state = SEARCH;
      endcase
    end
  end

  always_comb begin
    slip        = 1'b0;
    miss_inc    = 1'b0;
    match_first = 1'b0;
    match_inc   = 1'b0;
    match_clr   = 1'b0;
    load_data   = 1'b0;
    if (boundary && !resync) begin
      case (state)
        SEARCH:  if (is_match) match_first = 1'b1;
                 else begin slip = 1'b1; miss_inc = 1'b1; end
        VERIFY:  if (is_match) match_inc = 1'b1;
                 else begin slip = 1'b1; match_clr = 1'b1; end
        LOCKED:  load_data = 1'b1;
        default: ;
      endcase
    end
  end

  // data_out is deliberately left alone by resync; it holds the last delivered word.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      match_cnt  <= '0;
      miss_cnt   <= '0;
      slip_cnt   <= '0;
      align_err  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (resync) begin
      match_cnt  <= '0;
      miss_cnt   <= '0;
      slip_cnt   <= '0;
      align_err  <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= load_data;
      if (load_data) data_out <= candidate;
      if (match_first)    match_cnt <= 4'd1;
      else if (match_inc) match_cnt <= match_cnt + 4'd1;
      else if (match_clr) match_cnt <= '0;
      if (slip) slip_cnt <= slip_cnt + 3'd1;
      if (miss_inc && miss_cnt != MISS_MAX) miss_cnt <= miss_cnt + 8'd1;
      if (miss_inc && miss_cnt == MISS_LAST) align_err <= 1'b1;
    end
  end

endmodule
